uart_tx_arbiter: RTL and testbench

Shares the single board UART transmit serializer (115200 baud, 434 clocks per bit at 50 MHz) between two byte producers. Typical producers are the j1eforth CPU terminal output and a status/debug streamer. Each requester owns a small FIFO. A round-robin scheduler with an optional per-requester lock picks the next byte, and a sequencing FSM drives the serializer's one-cycle data-valid handshake and tracks its active/done status. The block sits between the producers and the serializer in the board top level.

---
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit serializer between two byte producers, each with its own FIFO.
// A round-robin scheduler with per-requester lock feeds a start/active/done sequencing FSM.
module uart_tx_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_lock,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_lock,
    output logic [7:0] tx_byte,
    output logic       tx_dv,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic [1:0] grant,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACT, WAIT_DONE} state_t;

    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    state_t             state, state_next;
    logic [7:0]         mem [2][FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr [2];
    logic [FIFO_AW-1:0] rd_ptr [2];
    logic [FIFO_AW:0]   count  [2];
    logic [7:0]         push_data [2];
    logic [1:0]         valid, ready, lock, push, pop, not_empty;
    logic               last;       // last-granted requester
    logic               sel, sel_valid, load;

    assign push_data[0] = req0_data;
    assign push_data[1] = req1_data;
    assign valid        = {req1_valid, req0_valid};
    assign lock         = {req1_lock, req0_lock};
    assign req0_ready   = ready[0];
    assign req1_ready   = ready[1];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ready[i]     = (count[i] != FULL_COUNT);
            not_empty[i] = (count[i] != '0);
        end
        push = valid & ready;
        pop  = 2'b00;
        if (state == ISSUE) pop[last] = 1'b1;
    end

    // NOTE: FIFO storage carries no reset; pointers and counts define what is valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++)
            if (push[i]) mem[i][wr_ptr[i]] <= push_data[i];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
                else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
            end
        end
    end

    // A locked last owner is the only candidate, even when its FIFO is empty.
    always_comb begin
        sel       = ~last;
        sel_valid = 1'b0;
        if (lock[last]) begin
            sel       = last;
            sel_valid = not_empty[last];
        end else if (not_empty[~last]) begin
            sel       = ~last;
            sel_valid = 1'b1;
        end else if (not_empty[last]) begin
            sel       = last;
            sel_valid = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        tx_dv      = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (!tx_active && sel_valid) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                tx_dv      = 1'b1;
                state_next = WAIT_ACT;
            end
            WAIT_ACT: begin
                if (tx_done)        state_next = IDLE;
                else if (tx_active) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            tx_byte <= 8'h00;
            grant   <= 2'b00;
            last    <= 1'b1;
        end else begin
            state <= state_next;
            if (load) begin
                tx_byte <= mem[sel][rd_ptr[sel]];
                grant   <= sel ? 2'b10 : 2'b01;
                last    <= sel;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized
// two-producer run scored against per-requester byte queues and a serializer model.
module tb_uart_tx_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] req0_data, req1_data;
    logic       req0_valid, req1_valid, req0_lock, req1_lock;
    logic       req0_ready, req1_ready;
    logic [7:0] tx_byte;
    logic       tx_dv, tx_active, tx_done;
    logic [1:0] grant;
    logic       busy;

    logic       ser_auto, ser_active, ser_done, man_active, man_done;
    logic       prev_dv;
    int         checks = 0;
    int         errors = 0;
    int         ser_lat, ser_len;
    logic [9:0] cap_q [$];
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];

    assign tx_active = ser_auto ? ser_active : man_active;
    assign tx_done   = ser_auto ? ser_done   : man_done;

    always #5 clock = ~clock;

    uart_tx_arbiter #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lock(req0_lock),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_lock(req1_lock),
        .tx_byte(tx_byte), .tx_dv(tx_dv), .tx_active(tx_active), .tx_done(tx_done),
        .grant(grant), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Every start pulse the serializer sees, tagged with the grant in force.
    always begin
        @(posedge clock);
        #2;
        if (tx_dv) cap_q.push_back({grant, tx_byte});
    end

    // Behavioural serializer: starts a short frame after each start pulse.
    always begin
        @(posedge clock);
        #2;
        if (ser_auto && tx_dv) begin
            ser_lat = $urandom_range(0, 2);
            ser_len = $urandom_range(2, 8);
            repeat (ser_lat + 1) @(posedge clock);
            #2 ser_active = 1'b1;
            repeat (ser_len) @(posedge clock);
            #2;
            ser_active = 1'b0;
            ser_done   = 1'b1;
            @(posedge clock);
            #2 ser_done = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (reset_n && tx_dv) begin
            check("dv_while_active", {31'd0, tx_active}, 32'd0);
            check("dv_back_to_back", {31'd0, prev_dv}, 32'd0);
        end
        prev_dv <= tx_dv;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        cap_q.delete();
    endtask

    task automatic push(input int i, input logic [7:0] d);
        logic rdy;
        bit   ok;
        ok = 1'b0;
        if (i == 0) begin req0_data = d; req0_valid = 1'b1; end
        else        begin req1_data = d; req1_valid = 1'b1; end
        for (int t = 0; t < 3000; t++) begin
            rdy = (i == 0) ? req0_ready : req1_ready;
            @(posedge clock);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            #1;
        end
        if (ok) #1;
        if (i == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
        if (ok) begin
            if (i == 0) exp0.push_back(d);
            else        exp1.push_back(d);
        end else begin
            check("push_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_caps(input int n, input int budget, input string tag);
        int t;
        t = 0;
        while (cap_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        check(tag, {31'd0, cap_q.size() >= n}, 32'd1);
    endtask

    task automatic wait_dv(input string tag);
        int t;
        t = 0;
        while (!tx_dv && t < 200) begin
            tick();
            t++;
        end
        check(tag, {31'd0, tx_dv}, 32'd1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || ser_active) && t < 500) begin
            tick();
            t++;
        end
        check("drain_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_cap(input string tag, input logic [1:0] g, input logic [7:0] b);
        logic [9:0] e;
        if (cap_q.size() == 0) begin
            check({tag, "_missing"}, 32'd0, 32'd1);
        end else begin
            e = cap_q.pop_front();
            check(tag, {22'd0, e}, {22'd0, g, b});
        end
    endtask

    // Finishes a manually driven frame from WAIT_ACT back to IDLE.
    task automatic man_frame_rest();
        man_active = 1'b1;
        tick();
        tick();
        man_active = 1'b0;
        man_done   = 1'b1;
        tick();
        man_done   = 1'b0;
    endtask

    initial begin
        logic [9:0] e;
        reset_n    = 1'b0;
        req0_data  = 8'h00; req1_data  = 8'h00;
        req0_valid = 1'b0;  req1_valid = 1'b0;
        req0_lock  = 1'b0;  req1_lock  = 1'b0;
        ser_auto   = 1'b0;  ser_active = 1'b0; ser_done = 1'b0;
        man_active = 1'b0;  man_done   = 1'b0;
        prev_dv    = 1'b0;
        #1;
        check("rst_dv",      {31'd0, tx_dv},      32'd0);
        check("rst_busy",    {31'd0, busy},       32'd0);
        check("rst_ready0",  {31'd0, req0_ready}, 32'd1);
        check("rst_ready1",  {31'd0, req1_ready}, 32'd1);
        do_reset();
        check("rst_grant",   {30'd0, grant},      32'd0);
        check("rst_byte",    {24'd0, tx_byte},    32'd0);

        // Single byte: start pulse two edges after the push edge.
        push(0, 8'h41);
        check("single_no_dv_early", {31'd0, tx_dv}, 32'd0);
        tick();
        check("single_dv",    {31'd0, tx_dv},   32'd1);
        check("single_byte",  {24'd0, tx_byte}, 32'h41);
        check("single_grant", {30'd0, grant},   32'd1);
        check("single_busy",  {31'd0, busy},    32'd1);
        tick();
        check("single_dv_once", {31'd0, tx_dv}, 32'd0);
        man_active = 1'b1;
        tick();
        tick();
        man_active = 1'b0;
        man_done   = 1'b1;
        check("single_busy_before_done", {31'd0, busy}, 32'd1);
        tick();
        man_done = 1'b0;
        check("single_busy_fall", {31'd0, busy}, 32'd0);
        check("single_byte_held", {24'd0, tx_byte}, 32'h41);
        expect_cap("single_cap", 2'b01, 8'h41);

        // Round robin from reset: requester 0 wins the first tie.
        do_reset();
        man_active = 1'b1;
        push(0, 8'h30); push(0, 8'h31);
        push(1, 8'h61); push(1, 8'h62);
        ser_auto = 1'b1; man_active = 1'b0;
        wait_caps(4, 500, "rr_count");
        expect_cap("rr_0", 2'b01, 8'h30);
        expect_cap("rr_1", 2'b10, 8'h61);
        expect_cap("rr_2", 2'b01, 8'h31);
        expect_cap("rr_3", 2'b10, 8'h62);
        wait_idle();

        // Lock: requester 1 keeps the serializer until its lock drops.
        ser_auto = 1'b0;
        do_reset();
        man_active = 1'b1;
        push(1, 8'hB1); push(1, 8'hB2); push(1, 8'hB3);
        push(0, 8'h55);
        req1_lock = 1'b1;
        ser_auto = 1'b1; man_active = 1'b0;
        wait_caps(3, 500, "lock_count");
        expect_cap("lock_0", 2'b10, 8'hB1);
        expect_cap("lock_1", 2'b10, 8'hB2);
        expect_cap("lock_2", 2'b10, 8'hB3);
        repeat (40) tick();
        check("lock_holds_off", cap_q.size(), 32'd0);
        req1_lock = 1'b0;
        wait_caps(1, 200, "lock_release");
        expect_cap("lock_after", 2'b01, 8'h55);
        wait_idle();

        // FIFO full while the serializer is busy.
        ser_auto = 1'b0;
        do_reset();
        man_active = 1'b1;
        push(0, 8'hA0); push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
        check("full_ready", {31'd0, req0_ready}, 32'd0);
        req0_data = 8'hAF; req0_valid = 1'b1;
        repeat (3) tick();
        check("full_still_blocked", {31'd0, req0_ready}, 32'd0);
        req0_valid = 1'b0;
        man_active = 1'b0;
        tick();
        check("full_first_dv",   {31'd0, tx_dv},      32'd1);
        check("full_ready_pre",  {31'd0, req0_ready}, 32'd0);
        tick();
        check("full_ready_back", {31'd0, req0_ready}, 32'd1);
        man_frame_rest();
        for (int k = 0; k < 3; k++) begin
            wait_dv("full_dv");
            tick();
            man_frame_rest();
        end
        repeat (20) tick();
        check("full_cap_count", cap_q.size(), 32'd4);
        expect_cap("full_0", 2'b01, 8'hA0);
        expect_cap("full_1", 2'b01, 8'hA1);
        expect_cap("full_2", 2'b01, 8'hA2);
        expect_cap("full_3", 2'b01, 8'hA3);

        // Reset in WAIT_DONE with the serializer still active.
        do_reset();
        push(0, 8'h11);
        push(1, 8'h22);
        wait_dv("mid_dv");
        tick();
        man_active = 1'b1;
        tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_dv",     {31'd0, tx_dv},      32'd0);
        check("mid_rst_byte",   {24'd0, tx_byte},    32'd0);
        check("mid_rst_grant",  {30'd0, grant},      32'd0);
        check("mid_rst_busy",   {31'd0, busy},       32'd0);
        check("mid_rst_ready0", {31'd0, req0_ready}, 32'd1);
        check("mid_rst_ready1", {31'd0, req1_ready}, 32'd1);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        cap_q.delete();
        push(0, 8'h33);
        repeat (10) tick();
        check("mid_no_dv_while_active", cap_q.size(), 32'd0);
        check("mid_idle_while_active",  {31'd0, busy}, 32'd0);
        man_active = 1'b0;
        wait_dv("mid_dv_after");
        tick();
        man_frame_rest();
        repeat (20) tick();
        check("mid_discarded", cap_q.size(), 32'd1);
        expect_cap("mid_new_byte", 2'b01, 8'h33);

        // Random producers with gaps, concurrent push/pop and pointer wrap.
        exp0.delete();
        exp1.delete();
        cap_q.delete();
        ser_auto = 1'b1;
        fork
            for (int k = 0; k < 20; k++) begin
                repeat ($urandom_range(0, 3)) tick();
                push(0, 8'($urandom));
            end
            for (int k = 0; k < 20; k++) begin
                repeat ($urandom_range(0, 3)) tick();
                push(1, 8'($urandom));
            end
        join
        wait_caps(40, 8000, "rand_count");
        wait_idle();
        repeat (10) tick();
        check("rand_exact_count", cap_q.size(), 32'd40);
        while (cap_q.size() > 0) begin
            e = cap_q.pop_front();
            if (e[9:8] == 2'b01 && exp0.size() > 0)
                check("rand_req0_order", {24'd0, e[7:0]}, {24'd0, exp0.pop_front()});
            else if (e[9:8] == 2'b10 && exp1.size() > 0)
                check("rand_req1_order", {24'd0, e[7:0]}, {24'd0, exp1.pop_front()});
            else
                check("rand_unexpected", {22'd0, e}, 32'hFFFF);
        end
        check("rand_req0_left", exp0.size(), 32'd0);
        check("rand_req1_left", exp1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
